// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter driving a 4:1 mux select.
// One dead cycle separates grants; hold time is capped at MAX_HOLD.
module rr_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic [7:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;
  logic       rel;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel = done | ~req[sel_q] | (cnt_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign valid    = valid_q;
  assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: MAX_HOLD=8 and MAX_HOLD=1 instances,
// directed scenarios then random traffic against a reference model.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req  [2];
  logic       done [2];
  logic [1:0] sel  [2];
  logic [3:0] gnt  [2];
  logic       valid[2];
  logic [7:0] hc   [2];

  int tests = 0;
  int fails = 0;

  bit m_busy[2];
  int m_sel [2];
  int m_cnt [2];
  int m_ptr [2];
  int MH    [2] = '{8, 1};

  always #5 clk = ~clk;

  rr_sel_arbiter #(.MAX_HOLD(8)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .done(done[0]),
    .sel(sel[0]), .gnt(gnt[0]), .valid(valid[0]), .hold_cnt(hc[0])
  );

  rr_sel_arbiter #(.MAX_HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .done(done[1]),
    .sel(sel[1]), .gnt(gnt[1]), .valid(valid[1]), .hold_cnt(hc[1])
  );

  task automatic chk(string tag, int i, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic expect_st(string tag, int i, logic [3:0] g,
                           logic [1:0] s, logic v, logic [7:0] c);
    chk({tag, "_gnt"}, i, 8'(gnt[i]), 8'(g));
    chk({tag, "_sel"}, i, 8'(sel[i]), 8'(s));
    chk({tag, "_valid"}, i, 8'(valid[i]), 8'(v));
    chk({tag, "_cnt"}, i, hc[i], c);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_sel[i]  = 0;
      m_cnt[i]  = 0;
      m_ptr[i]  = 0;
    end
  endtask

  task automatic model_step(int i);
    int c;
    if (!m_busy[i]) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr[i] + k) % 4;
        if (!m_busy[i] && req[i][c]) begin
          m_busy[i] = 1'b1;
          m_sel[i]  = c;
          m_cnt[i]  = 1;
        end
      end
    end else if (done[i] || !req[i][m_sel[i]] || m_cnt[i] == MH[i]) begin
      m_busy[i] = 1'b0;
      m_cnt[i]  = 0;
      m_ptr[i]  = (m_sel[i] + 1) % 4;
    end else begin
      m_cnt[i]++;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    for (int i = 0; i < 2; i++) begin
      eg = m_busy[i] ? 4'(1 << m_sel[i]) : 4'b0000;
      expect_st("model", i, eg, 2'(m_sel[i]), m_busy[i], 8'(m_cnt[i]));
      chk("onehot", i, 8'($onehot0(gnt[i])), 8'd1);
      chk("valid_or", i, 8'(valid[i]), 8'(|gnt[i]));
      chk("gnt_sel", i, 8'(!valid[i] || gnt[i][sel[i]]), 8'd1);
      chk("hold_max", i, 8'(hc[i] <= 8'(MH[i])), 8'd1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_model();
  endtask

  // Asynchronous reset applied between edges.
  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    expect_st(tag, 0, 4'b0000, 2'd0, 1'b0, 8'd0);
    expect_st(tag, 1, 4'b0000, 2'd0, 1'b0, 8'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req[0]  = '0;
    req[1]  = '0;
    done[0] = 1'b0;
    done[1] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_st("rst", 0, 4'b0000, 2'd0, 1'b0, 8'd0);
    expect_st("rst", 1, 4'b0000, 2'd0, 1'b0, 8'd0);
    rst_n = 1'b1;

    req[0] = 4'b1111;
    req[1] = 4'b1010;
    cycle();
    expect_st("s29_c1", 0, 4'b0001, 2'd0, 1'b1, 8'd1);
    expect_st("s34_c1", 1, 4'b0010, 2'd1, 1'b1, 8'd1);
    cycle();
    expect_st("s34_c2", 1, 4'b0000, 2'd1, 1'b0, 8'd0);
    cycle();
    expect_st("s34_c3", 1, 4'b1000, 2'd3, 1'b1, 8'd1);
    cycle();
    expect_st("s34_c4", 1, 4'b0000, 2'd3, 1'b0, 8'd0);
    cycle();
    expect_st("s34_c5", 1, 4'b0010, 2'd1, 1'b1, 8'd1);
    repeat (3) cycle();
    expect_st("s29_c8", 0, 4'b0001, 2'd0, 1'b1, 8'd8);
    cycle();
    expect_st("s29_gap", 0, 4'b0000, 2'd0, 1'b0, 8'd0);
    cycle();
    expect_st("s29_ch1", 0, 4'b0010, 2'd1, 1'b1, 8'd1);
    repeat (26) cycle();
    expect_st("s29_gap3", 0, 4'b0000, 2'd3, 1'b0, 8'd0);
    cycle();
    expect_st("s29_ch0", 0, 4'b0001, 2'd0, 1'b1, 8'd1);
    req[0] = '0;
    req[1] = '0;
    repeat (2) cycle();
    do_reset("r1");

    req[0] = 4'b0100;
    cycle();
    expect_st("s30_c1", 0, 4'b0100, 2'd2, 1'b1, 8'd1);
    cycle();
    cycle();
    expect_st("s30_c3", 0, 4'b0100, 2'd2, 1'b1, 8'd3);
    done[0] = 1'b1;
    cycle();
    expect_st("s30_idle", 0, 4'b0000, 2'd2, 1'b0, 8'd0);
    done[0] = 1'b0;
    req[0]  = 4'b0011;
    cycle();
    expect_st("s31_wrap", 0, 4'b0001, 2'd0, 1'b1, 8'd1);
    done[0] = 1'b1;
    cycle();
    done[0] = 1'b0;
    cycle();
    expect_st("s31_ch1", 0, 4'b0010, 2'd1, 1'b1, 8'd1);
    cycle();
    done[0] = 1'b1;
    cycle();
    done[0] = 1'b0;

    req[0] = 4'b0010;
    cycle();
    expect_st("s32_c1", 0, 4'b0010, 2'd1, 1'b1, 8'd1);
    cycle();
    req[0] = 4'b1000;
    cycle();
    expect_st("s32_rel", 0, 4'b0000, 2'd1, 1'b0, 8'd0);
    cycle();
    expect_st("s32_ch3", 0, 4'b1000, 2'd3, 1'b1, 8'd1);

    req[0]  = 4'b0100;
    done[0] = 1'b1;
    cycle();
    done[0] = 1'b0;
    cycle();
    expect_st("s33_ch2", 0, 4'b0100, 2'd2, 1'b1, 8'd1);
    cycle();
    do_reset("s33_rst");
    cycle();
    expect_st("s33_regrant", 0, 4'b0100, 2'd2, 1'b1, 8'd1);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = 4'($urandom_range(0, 15));
        done[i] = ($urandom_range(0, 4) == 0);
      end
      if (n == 300) do_reset("rnd_rst");
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
